apb_csr_control: RTL and testbench
==================================

Name: apb_csr_control

Overview:
- APB slave front-end and control sequencer for the ALU CSR block; sits directly upstream of the CSR register bank.
- Decodes APB transfers into one-cycle register write enables and forwards write data.
- Turns the register bank's start pulse into a FIFO_IN push, holding it back while FIFO_IN is full.
- Sequences RESULT reads: holds the result register enabled, pops FIFO_OUT, and returns read data with one wait state.

Parameters:
- APB_BUS_SIZE, 32, APB data width.
- ADDR_SIZE, 8, APB address width; only paddr[4:2] are decoded.
- FIFO_OUT_WIDTH, 25, width of final_result and fifo_out_status.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction; 1 = write.
- paddr  in  ADDR_SIZE  APB byte address.
- pwdata  in  APB_BUS_SIZE  APB write data.
- prdata  out  APB_BUS_SIZE  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- wdata  out  APB_BUS_SIZE  write data to the register bank; equals pwdata.
- en_ctrl  out  1  CTRL register write enable.
- en_data0  out  1  DATA_0 register write enable.
- en_data1  out  1  DATA_1 register write enable.
- start_bit  in  1  one-cycle start pulse from the register bank.
- in_full  in  1  FIFO_IN full flag.
- w_en_in  out  1  FIFO_IN push.
- out_empty  in  1  FIFO_OUT empty flag.
- out_rd_en  out  1  FIFO_OUT pop; FIFO_OUT is show-ahead.
- r_en_out  out  1  result-register hold; the result register clears whenever this is 0.
- final_result  in  FIFO_OUT_WIDTH  RESULT register value.
- fifo_out_status  in  FIFO_OUT_WIDTH  STATUS register value.
- start_overrun  out  1  sticky flag: a start pulse was dropped.

Behaviour:
- Reset (async, rst=1): state=IDLE; pending=0; start_overrun=0. All outputs are 0, except wdata, which always follows pwdata.
- Address map (paddr[4:2]): 0 = CTRL (W), 1 = DATA_0 (W), 2 = DATA_1 (W), 3 = RESULT (R), 4 = STATUS (R). Any other address is an error.
- Setup phase = psel & !penable. Access phase = psel & penable.
- Writes: zero wait states; pready=1 in the access phase.
  - en_ctrl/en_data0/en_data1 are combinational decodes of access & pwrite & address, so each is high exactly during the access cycle.
  - Write to a read-only or unmapped address: pslverr=1, no enable asserted.
- Read STATUS: zero wait states; prdata = zero-extended fifo_out_status.
- Read unmapped address, or RESULT while out_empty=1: zero wait states; prdata=0, pslverr=1, no pop, r_en_out stays 0.
- RESULT read FSM (states IDLE, RD_CAP, RD_ACC):
  - IDLE -> RD_CAP: setup phase, read, address 3, out_empty=0.
  - RD_CAP: r_en_out=1, pready=0. The result register captures the FIFO_OUT head at the clock edge.
  - RD_ACC: r_en_out=1, pready=1, prdata = zero-extended final_result, out_rd_en=1 for exactly this cycle. Next state: IDLE.
  - Back in IDLE, r_en_out=0, so final_result clears.
  - Read latency: setup + 1 wait + access = 3 cycles. Exactly one FIFO entry is popped per RESULT read.
  - If psel drops while in RD_CAP or RD_ACC, the FSM returns to IDLE with no pop.
- Start/push:
  - start_bit=1 and in_full=0 and pending=0: w_en_in=1 in the same cycle.
  - start_bit=1 and in_full=1: pending<=1.
  - pending=1 and in_full=0: w_en_in=1 for one cycle, then pending<=0.
  - start_bit=1 while pending=1: the pulse is dropped and start_overrun<=1 (cleared only by rst).
  - At most one w_en_in per start.
- A push (start path) and a RESULT pop (read FSM) are independent and may occur in the same cycle.
- rst asserted mid-transfer or mid-pending: immediate return to reset values; any pending push is lost.

Test Plan:
- Write 0x0000_0A03 to addr 0x00 -> en_ctrl high exactly one cycle (the access cycle), wdata=0x0000_0A03, pready=1, pslverr=0; en_data0 and en_data1 stay 0.
- Pulse start_bit with in_full=0 -> w_en_in high in that same cycle only. Repeat with in_full=1 held 5 cycles -> no push until in_full falls, then w_en_in exactly one cycle.
- With pending=1, pulse start_bit again -> start_overrun=1 and only one w_en_in after in_full falls.
- FIFO_OUT head=0x1ABCDE, out_empty=0; read addr 0x0C -> pready low one cycle, then prdata=0x001ABCDE with pready=1; out_rd_en one pulse; r_en_out high two cycles; final_result returns to 0 afterwards.
- Read addr 0x0C with out_empty=1 -> prdata=0, pslverr=1, out_rd_en=0. Write to addr 0x14 -> pslverr=1, no enable asserted.
- Assert rst during RD_CAP and while pending=1 -> r_en_out, pready, w_en_in and start_overrun all go to 0 immediately; no later push or pop occurs.

Source files
------------

// File: rtl/apb_csr_control.sv
// APB slave front-end for the ALU CSR block: write-enable decode, FIFO_IN start/push
// sequencing and the one-wait-state RESULT read that pops FIFO_OUT.
module apb_csr_control #(
  parameter int APB_BUS_SIZE   = 32,
  parameter int ADDR_SIZE      = 8,
  parameter int FIFO_OUT_WIDTH = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_SIZE-1:0]      paddr,
  input  logic [APB_BUS_SIZE-1:0]   pwdata,
  output logic [APB_BUS_SIZE-1:0]   prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [APB_BUS_SIZE-1:0]   wdata,
  output logic                      en_ctrl,
  output logic                      en_data0,
  output logic                      en_data1,
  input  logic                      start_bit,
  input  logic                      in_full,
  output logic                      w_en_in,
  input  logic                      out_empty,
  output logic                      out_rd_en,
  output logic                      r_en_out,
  input  logic [FIFO_OUT_WIDTH-1:0] final_result,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
  output logic                      start_overrun
);

  typedef enum logic [1:0] {IDLE, RD_CAP, RD_ACC} state_t;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DATA0  = 3'd1;
  localparam logic [2:0] ADDR_DATA1  = 3'd2;
  localparam logic [2:0] ADDR_RESULT = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  state_t state_q, state_d;
  logic   pending_q, pending_d;
  logic   start_overrun_q, start_overrun_d;

  logic [2:0] addr;
  logic       setup;
  logic       access;
  logic [APB_BUS_SIZE-1:0] result_ext;
  logic [APB_BUS_SIZE-1:0] status_ext;
  logic       unused_paddr_bits;

  assign addr       = paddr[4:2];
  assign setup      = psel & ~penable;
  assign access     = psel & penable;
  assign result_ext = {{(APB_BUS_SIZE-FIFO_OUT_WIDTH){1'b0}}, final_result};
  assign status_ext = {{(APB_BUS_SIZE-FIFO_OUT_WIDTH){1'b0}}, fifo_out_status};
  assign unused_paddr_bits = ^{paddr[ADDR_SIZE-1:5], paddr[1:0]};

  assign wdata         = pwdata;
  assign start_overrun = start_overrun_q;

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    start_overrun_d = start_overrun_q;
    prdata          = '0;
    pready          = 1'b0;
    pslverr         = 1'b0;
    en_ctrl         = 1'b0;
    en_data0        = 1'b0;
    en_data1        = 1'b0;
    out_rd_en       = 1'b0;
    r_en_out        = 1'b0;
    w_en_in         = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup && !pwrite && addr == ADDR_RESULT && !out_empty) state_d = RD_CAP;
        if (access) begin
          pready = 1'b1;
          if (pwrite) begin
            case (addr)
              ADDR_CTRL:  en_ctrl  = 1'b1;
              ADDR_DATA0: en_data0 = 1'b1;
              ADDR_DATA1: en_data1 = 1'b1;
              default:    pslverr  = 1'b1;
            endcase
          end else if (addr == ADDR_STATUS) begin
            prdata = status_ext;
          end else begin
            // RESULT only reaches IDLE's access phase when FIFO_OUT was empty at setup
            pslverr = 1'b1;
          end
        end
      end
      RD_CAP: begin
        r_en_out = 1'b1;
        state_d  = psel ? RD_ACC : IDLE;
      end
      RD_ACC: begin
        r_en_out = 1'b1;
        state_d  = IDLE;
        if (access) begin
          pready    = 1'b1;
          prdata    = result_ext;
          out_rd_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A held start drains first; a new start while one is held is dropped
    if (pending_q) begin
      if (!in_full) begin
        w_en_in   = 1'b1;
        pending_d = 1'b0;
      end
      if (start_bit) start_overrun_d = 1'b1;
    end else if (start_bit) begin
      if (in_full) pending_d = 1'b1;
      else         w_en_in   = 1'b1;
    end

    if (rst) begin
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      en_ctrl   = 1'b0;
      en_data0  = 1'b0;
      en_data1  = 1'b0;
      out_rd_en = 1'b0;
      r_en_out  = 1'b0;
      w_en_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      pending_q       <= 1'b0;
      start_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      start_overrun_q <= start_overrun_d;
    end
  end

endmodule

// File: tb/tb_apb_csr_control.sv
// Directed bench for apb_csr_control: APB completions go through a scoreboard queue,
// start/push and reset behaviour are checked against hand-computed values.
module tb_apb_csr_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] wdata;
  logic        en_ctrl, en_data0, en_data1;
  logic        start_bit, in_full, w_en_in;
  logic        out_empty, out_rd_en, r_en_out;
  logic [24:0] final_result, fifo_out_status, fifo_head;
  logic        start_overrun;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        slverr;
    logic [2:0]  en;
    logic        rd_en;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   push_cnt = 0, pop_cnt = 0, ren_cnt = 0, ctrl_cnt = 0, d0_cnt = 0, d1_cnt = 0;

  always #5 clk = ~clk;

  apb_csr_control dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .wdata(wdata), .en_ctrl(en_ctrl), .en_data0(en_data0), .en_data1(en_data1),
    .start_bit(start_bit), .in_full(in_full), .w_en_in(w_en_in),
    .out_empty(out_empty), .out_rd_en(out_rd_en), .r_en_out(r_en_out),
    .final_result(final_result), .fifo_out_status(fifo_out_status),
    .start_overrun(start_overrun)
  );

  // Result register of the downstream bank: captures the FIFO_OUT head while held
  always @(posedge clk or posedge rst) begin
    if (rst)           final_result <= '0;
    else if (r_en_out) final_result <= fifo_head;
    else               final_result <= '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts strobes and scores every completed APB transfer
  always @(negedge clk) begin
    if (w_en_in)   push_cnt++;
    if (out_rd_en) pop_cnt++;
    if (r_en_out)  ren_cnt++;
    if (en_ctrl)   ctrl_cnt++;
    if (en_data0)  d0_cnt++;
    if (en_data1)  d1_cnt++;
    if (psel && penable && pready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk_rd) check("prdata", prdata, e.rdata);
        check("pslverr", {31'd0, pslverr}, {31'd0, e.slverr});
        check("enables", {29'd0, en_data1, en_data0, en_ctrl}, {29'd0, e.en});
        check("out_rd_en", {31'd0, out_rd_en}, {31'd0, e.rd_en});
      end
    end
  end

  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     input int exp_waits, input exp_t e);
    int  waits;
    logic done;
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
        break;
      end
      waits++;
    end
    check("pready_seen", {31'd0, done}, 32'd1);
    check("wait_states", waits, exp_waits);
    if (wr) check("wdata", wdata, d);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse_start(input logic exp_push);
    @(posedge clk); #1;
    start_bit = 1'b1;
    @(negedge clk);
    check("w_en_in_on_start", {31'd0, w_en_in}, {31'd0, exp_push});
    @(posedge clk); #1;
    start_bit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_push, base_pop, base_ren, base_c, base_0, base_1;
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h10;
    pwdata = 32'hDEAD_BEEF; start_bit = 1'b1; in_full = 1'b0; out_empty = 1'b0;
    fifo_head = 25'h1ABCDE; fifo_out_status = 25'h1F0F0F0;

    // Reset: every output but wdata is 0 even with an active access and start
    @(negedge clk);
    check("rst_prdata", prdata, 32'd0);
    check("rst_ctrl_outs", {25'd0, pready, pslverr, en_ctrl, en_data0, en_data1, w_en_in, out_rd_en},
          32'd0);
    check("rst_r_en_out_ovr", {30'd0, r_en_out, start_overrun}, 32'd0);
    check("rst_wdata", wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; start_bit = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Register writes
    base_c = ctrl_cnt; base_0 = d0_cnt; base_1 = d1_cnt;
    apb(1'b1, 8'h00, 32'h0000_0A03, 0, '{chk_rd: 1'b0, rdata: 32'd0, slverr: 1'b0, en: 3'b001, rd_en: 1'b0});
    idle(2);
    check("en_ctrl_cycles", ctrl_cnt - base_c, 1);
    check("en_data_quiet", (d0_cnt - base_0) + (d1_cnt - base_1), 0);
    apb(1'b1, 8'h04, 32'h1234_5678, 0, '{chk_rd: 1'b0, rdata: 32'd0, slverr: 1'b0, en: 3'b010, rd_en: 1'b0});
    apb(1'b1, 8'h08, 32'h8765_4321, 0, '{chk_rd: 1'b0, rdata: 32'd0, slverr: 1'b0, en: 3'b100, rd_en: 1'b0});
    // Writes to read-only and unmapped addresses
    apb(1'b1, 8'h0C, 32'h0000_0001, 0, '{chk_rd: 1'b0, rdata: 32'd0, slverr: 1'b1, en: 3'b000, rd_en: 1'b0});
    apb(1'b1, 8'h14, 32'h0000_0002, 0, '{chk_rd: 1'b0, rdata: 32'd0, slverr: 1'b1, en: 3'b000, rd_en: 1'b0});

    // STATUS and unmapped reads
    apb(1'b0, 8'h10, 32'd0, 0, '{chk_rd: 1'b1, rdata: 32'h01F0_F0F0, slverr: 1'b0, en: 3'b000, rd_en: 1'b0});
    apb(1'b0, 8'h1C, 32'd0, 0, '{chk_rd: 1'b1, rdata: 32'd0, slverr: 1'b1, en: 3'b000, rd_en: 1'b0});

    // RESULT read with data available: one wait state, one pop, r_en_out two cycles
    base_pop = pop_cnt; base_ren = ren_cnt;
    apb(1'b0, 8'h0C, 32'd0, 1, '{chk_rd: 1'b1, rdata: 32'h001A_BCDE, slverr: 1'b0, en: 3'b000, rd_en: 1'b1});
    idle(2);
    @(negedge clk);
    check("pop_count", pop_cnt - base_pop, 1);
    check("r_en_out_cycles", ren_cnt - base_ren, 2);
    check("final_result_cleared", {7'd0, final_result}, 32'd0);

    // RESULT read with FIFO_OUT empty
    out_empty = 1'b1;
    base_pop = pop_cnt; base_ren = ren_cnt;
    apb(1'b0, 8'h0C, 32'd0, 0, '{chk_rd: 1'b1, rdata: 32'd0, slverr: 1'b1, en: 3'b000, rd_en: 1'b0});
    idle(1);
    check("empty_no_pop", pop_cnt - base_pop, 0);
    check("empty_no_r_en", ren_cnt - base_ren, 0);
    out_empty = 1'b0;

    // Start with FIFO_IN not full: push in the same cycle only
    base_push = push_cnt;
    pulse_start(1'b1);
    idle(3);
    check("push_direct", push_cnt - base_push, 1);

    // Start with FIFO_IN full: held until in_full falls, then one push
    base_push = push_cnt;
    in_full = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("held_no_push", {31'd0, w_en_in}, 32'd0);
    end
    @(posedge clk); #1;
    in_full = 1'b0;
    @(negedge clk);
    check("deferred_push", {31'd0, w_en_in}, 32'd1);
    idle(3);
    check("deferred_push_count", push_cnt - base_push, 1);
    check("no_overrun_yet", {31'd0, start_overrun}, 32'd0);

    // Second start while one is pending: dropped, sticky overrun, single push
    base_push = push_cnt;
    in_full = 1'b1;
    pulse_start(1'b0);
    pulse_start(1'b0);
    @(negedge clk);
    check("overrun_set", {31'd0, start_overrun}, 32'd1);
    @(posedge clk); #1;
    in_full = 1'b0;
    idle(4);
    check("overrun_single_push", push_cnt - base_push, 1);
    check("overrun_sticky", {31'd0, start_overrun}, 32'd1);

    // Reset while RD_CAP and a pending push are both in flight
    in_full = 1'b1;
    pulse_start(1'b0);
    base_push = push_cnt; base_pop = pop_cnt;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0C;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    check("rd_cap_r_en_out", {31'd0, r_en_out}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {28'd0, r_en_out, pready, w_en_in, start_overrun}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; in_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    check("rst_no_push", push_cnt - base_push, 0);
    check("rst_no_pop", pop_cnt - base_pop, 0);
    check("rst_overrun_cleared", {31'd0, start_overrun}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
